retry_change_monitor: RTL and testbench
=======================================

Name: retry_change_monitor

Overview:
- Parametrised, multi-channel change monitor for link-layer retry observability signals (LRSM/RRSM state, retry counters, pointers, control strobes).
- Instead of printing on every change, it latches old/new values per channel, timestamps them, and queues one event per change in a FIFO behind a valid/ready port.
- Also keeps per-channel change counters and a count of coalesced (overwritten) changes.
- Sits beside the retry block in the link layer; drained by a debug/trace reader or by the testbench scoreboard.

Parameters:
- NUM_CH, 8, number of monitored channels (≥2).
- CH_W, 8, width of each channel; narrower signals are zero-extended by the integrator.
- FIFO_DEPTH, 16, event FIFO entries (power of two, ≥2).
- TS_W, 32, timestamp counter width.
- CNT_W, 16, width of the change counters and the coalesce counter.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_observer_on  in  1  monitor enable.
- i_ch_data  in  NUM_CH*CH_W  channel values; channel k occupies [k*CH_W +: CH_W].
- i_ch_mask  in  NUM_CH  per-channel enable; 1 = monitored.
- i_clr_cnt  in  1  synchronous clear of all counters.
- o_evt_valid  out  1  FIFO head valid.
- i_evt_ready  in  1  consumer accepts the head.
- o_evt_ch  out  $clog2(NUM_CH)  channel id of the head event.
- o_evt_old  out  CH_W  value before the change.
- o_evt_new  out  CH_W  value after the change (latest, if coalesced).
- o_evt_ts  out  TS_W  timestamp of the first detection.
- o_evt_coal  out  1  event absorbed at least one further change.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  occupancy.
- o_chg_cnt  out  NUM_CH*CNT_W  per-channel change counters.
- o_coal_cnt  out  CNT_W  total coalesced changes.

Behaviour:
- Reset: async. All outputs, prev-value regs, pending flags, FIFO pointers, counters and timestamp go to 0; FSM goes to IDLE.
- Timestamp: free-running from reset, +1 per cycle, wraps modulo 2^TS_W.
- FSM IDLE→PRIME when i_observer_on=1.
  - PRIME lasts one cycle: loads prev ← i_ch_data, detects nothing, then →ARMED.
  - Any state →IDLE when i_observer_on=0.
  - Entering IDLE clears all pending flags. FIFO contents are kept and stay drainable.
- Detection (ARMED only): chg[k] = i_ch_mask[k] & (i_ch_data[k] != prev[k]). prev is updated every ARMED cycle.
  - Masked channels still update prev, so unmasking never reports a stale difference.
- Pending slot per channel (old, new, ts, coal):
  - chg[k] with slot empty: fill old=prev, new=current, ts=now.
  - chg[k] with slot full: new=current, coal=1, o_coal_cnt+1.
- Arbiter: round-robin over pending slots, starting after the last granted channel. Pushes at most one slot per cycle into the FIFO and clears that slot.
  - Latency: input change sampled at edge N → pending at N → pushed at N+1 → o_evt_valid high after N+1 (2 cycles) when uncontended.
- Push/clear vs. new change, same edge: if the slot being pushed detects a new change on that edge, the pushed entry leaves unchanged and the slot refills as a fresh entry (no coalesce).
- FIFO:
  - Push when level<FIFO_DEPTH, or when full with a same-cycle pop. Otherwise the grant is withheld and the slot stays pending (no loss; later changes coalesce).
  - Pop on o_evt_valid & i_evt_ready.
  - o_evt_* are the head entry. They are 0 when empty and stable while valid & !ready.
- Counters: o_chg_cnt[k] increments on every chg[k], including coalesced ones. All counters saturate at 2^CNT_W−1.
  - i_clr_cnt zeroes o_chg_cnt and o_coal_cnt and wins over a same-cycle increment.
  - i_clr_cnt does not affect FIFO, pending slots or timestamp.

Optional Feature:
- Macro RETRY_CHG_MON_DISPLAY_EN.
- When defined: per-channel concurrent assertions, disabled while !i_rst_n or FSM!=ARMED or !i_ch_mask[k]. On change they $display "assert_msg:: ch <k> changed: <old> ----> <new>, @time = <t>".
- Also compiled in: protocol assertions that o_evt_* stay stable while valid & !ready, and that the FIFO never pushes when full without a pop.
- When undefined: no assertions and no $display; RTL behaviour is identical either way.

Decomposition:
- Package retry_chg_mon_pkg holds:
  - the FSM enum typedef (IDLE, PRIME, ARMED);
  - localparam helper functions for the id/level widths;
  - a message-prefix string constant.
- One sub-module: retry_chg_mon_fifo, a synchronous FIFO parametrised on entry width and depth, exposing level/full/empty. The monitor instantiates it with a packed {ch, old, new, ts, coal} entry.

Test Plan:
- Reset/prime: release reset, observer_on=1 with data≠0 → no event; level=0; all counters 0.
- Single change: ch2 0x00→0x5A at edge N → valid after N+1 with ch=2, old=0x00, new=0x5A, ts=N's timestamp, coal=0; o_chg_cnt[2]=1.
- Simultaneous changes: ch0, ch3, ch7 change on the same edge → three events on consecutive cycles in order 0, 3, 7; level peaks at 3.
- Backpressure/coalesce: FIFO_DEPTH=2, ready=0; ch1 changes 4 times → 2 events queued, 3rd slot pending. On ready=1 the 3rd event pops with coal=1 and the final value; o_coal_cnt equals the number of absorbed changes.
- Mask/disable: ch4 masked and toggled, then unmasked → no event. Observer_on dropped with 2 pending → pending discarded, queued events still drain; re-enable → PRIME, no spurious event.
- Mid-run reset and saturation: assert i_rst_n=0 with level=5 → all outputs 0 immediately. Separately, CNT_W=4 with 20 changes → counter holds 15; i_clr_cnt → 0.

Source files
------------

// File: rtl/retry_chg_mon_pkg.sv
// Shared types and helpers for the retry change monitor.
// Optional assertion/trace block is enabled with RETRY_CHG_MON_DISPLAY_EN.
package retry_chg_mon_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StArmed
  } mon_state_e;

  function automatic int unsigned id_width(int unsigned num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int unsigned level_width(int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  localparam string MsgPrefix = "assert_msg::";

endpackage

// File: rtl/retry_chg_mon_fifo.sv
// Synchronous FIFO with occupancy; head data reads as zero while empty.
module retry_chg_mon_fifo
  import retry_chg_mon_pkg::*;
#(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned LvlW = level_width(Depth)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [Width-1:0] i_wdata,
  output logic [Width-1:0] o_rdata,
  output logic [LvlW-1:0]  o_level,
  output logic             o_full,
  output logic             o_empty
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [LvlW-1:0]  level_q;
  logic             do_push, do_pop;

  assign o_empty = (level_q == '0);
  assign o_full  = (level_q == LvlW'(Depth));
  assign do_pop  = i_pop & ~o_empty;
  // A full FIFO still accepts a write when the head leaves on the same edge.
  assign do_push = i_push & (~o_full | do_pop);

  always_ff @(posedge i_clk) begin
    if (do_push) mem_q[wptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      if (do_push && !do_pop)      level_q <= level_q + 1'b1;
      else if (!do_push && do_pop) level_q <= level_q - 1'b1;
    end
  end

  assign o_rdata = o_empty ? '0 : mem_q[rptr_q];
  assign o_level = level_q;

endmodule

// File: rtl/retry_change_monitor.sv
// Multi-channel change monitor: per-channel pending slots, round-robin push into an event FIFO.
// Define RETRY_CHG_MON_DISPLAY_EN to compile change-trace and protocol assertions.
module retry_change_monitor
  import retry_chg_mon_pkg::*;
#(
  parameter int unsigned NUM_CH     = 8,
  parameter int unsigned CH_W       = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned TS_W       = 32,
  parameter int unsigned CNT_W      = 16,
  localparam int unsigned ID_W      = id_width(NUM_CH),
  localparam int unsigned LVL_W     = level_width(FIFO_DEPTH)
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_observer_on,
  input  logic [NUM_CH*CH_W-1:0]  i_ch_data,
  input  logic [NUM_CH-1:0]       i_ch_mask,
  input  logic                    i_clr_cnt,
  output logic                    o_evt_valid,
  input  logic                    i_evt_ready,
  output logic [ID_W-1:0]         o_evt_ch,
  output logic [CH_W-1:0]         o_evt_old,
  output logic [CH_W-1:0]         o_evt_new,
  output logic [TS_W-1:0]         o_evt_ts,
  output logic                    o_evt_coal,
  output logic [LVL_W-1:0]        o_fifo_level,
  output logic [NUM_CH*CNT_W-1:0] o_chg_cnt,
  output logic [CNT_W-1:0]        o_coal_cnt
);

  typedef struct packed {
    logic [ID_W-1:0] ch;
    logic [CH_W-1:0] old_val;
    logic [CH_W-1:0] new_val;
    logic [TS_W-1:0] ts;
    logic            coal;
  } evt_t;

  typedef struct packed {
    logic [CH_W-1:0] old_val;
    logic [CH_W-1:0] new_val;
    logic [TS_W-1:0] ts;
    logic            coal;
  } slot_t;

  mon_state_e       state_q, state_d;
  logic [TS_W-1:0]  ts_q;
  logic [ID_W-1:0]  rr_q;
  logic [CH_W-1:0]  ch_val [NUM_CH];
  logic [CH_W-1:0]  prev_q [NUM_CH];
  slot_t            slot_q [NUM_CH];
  slot_t            slot_d [NUM_CH];
  logic [NUM_CH-1:0] pend_q, pend_d, chg, coal_inc;
  logic [CNT_W-1:0] chg_cnt_q [NUM_CH];
  logic [CNT_W-1:0] chg_cnt_d [NUM_CH];
  logic [CNT_W-1:0] coal_cnt_q, coal_cnt_d;
  logic             armed, gnt_vld, can_push;
  logic [ID_W-1:0]  gnt_idx;
  evt_t             push_evt, head_evt;
  logic             fifo_full, fifo_empty, fifo_pop;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign ch_val[k] = i_ch_data[k*CH_W +: CH_W];
    assign o_chg_cnt[k*CNT_W +: CNT_W] = chg_cnt_q[k];
    assign chg[k] = armed & i_ch_mask[k] & (ch_val[k] != prev_q[k]);
  end

  always_comb begin
    state_d = state_q;
    if (!i_observer_on) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: state_d = StArmed;
        StArmed: state_d = StArmed;
        default: state_d = StIdle;
      endcase
    end
  end

  assign armed    = (state_q == StArmed) & i_observer_on;
  assign fifo_pop = o_evt_valid & i_evt_ready;
  assign can_push = ~fifo_full | fifo_pop;

  // Round-robin search begins at rr_q, the channel after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      int unsigned c;
      c = (32'(rr_q) + i) % NUM_CH;
      if (!gnt_vld && pend_q[c]) begin
        gnt_vld = 1'b1;
        gnt_idx = ID_W'(c);
      end
    end
    gnt_vld = gnt_vld & i_observer_on & can_push;
  end

  always_comb begin
    push_evt         = '0;
    push_evt.ch      = gnt_idx;
    push_evt.old_val = slot_q[gnt_idx].old_val;
    push_evt.new_val = slot_q[gnt_idx].new_val;
    push_evt.ts      = slot_q[gnt_idx].ts;
    push_evt.coal    = slot_q[gnt_idx].coal;
  end

  // A slot being pushed this edge refills as a fresh entry rather than coalescing.
  always_comb begin
    pend_d   = pend_q;
    slot_d   = slot_q;
    coal_inc = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (gnt_vld && gnt_idx == ID_W'(k)) pend_d[k] = 1'b0;
      if (chg[k]) begin
        if (pend_d[k]) begin
          slot_d[k].new_val = ch_val[k];
          slot_d[k].coal    = 1'b1;
          coal_inc[k]       = 1'b1;
        end else begin
          pend_d[k]         = 1'b1;
          slot_d[k].old_val = prev_q[k];
          slot_d[k].new_val = ch_val[k];
          slot_d[k].ts      = ts_q;
          slot_d[k].coal    = 1'b0;
        end
      end
    end
    if (state_d == StIdle) pend_d = '0;
  end

  always_comb begin
    coal_cnt_d = coal_cnt_q;
    for (int k = 0; k < NUM_CH; k++) begin
      chg_cnt_d[k] = chg_cnt_q[k];
      if (chg[k] && chg_cnt_q[k] != '1) chg_cnt_d[k] = chg_cnt_q[k] + 1'b1;
      if (coal_inc[k] && coal_cnt_d != '1) coal_cnt_d = coal_cnt_d + 1'b1;
    end
    if (i_clr_cnt) begin
      coal_cnt_d = '0;
      for (int k = 0; k < NUM_CH; k++) chg_cnt_d[k] = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StIdle;
      ts_q       <= '0;
      rr_q       <= '0;
      pend_q     <= '0;
      coal_cnt_q <= '0;
      for (int k = 0; k < NUM_CH; k++) begin
        prev_q[k]    <= '0;
        slot_q[k]    <= '0;
        chg_cnt_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_q + 1'b1;
      pend_q     <= pend_d;
      coal_cnt_q <= coal_cnt_d;
      if (gnt_vld) rr_q <= ID_W'((32'(gnt_idx) + 1) % NUM_CH);
      for (int k = 0; k < NUM_CH; k++) begin
        if (state_q != StIdle) prev_q[k] <= ch_val[k];
        slot_q[k]    <= slot_d[k];
        chg_cnt_q[k] <= chg_cnt_d[k];
      end
    end
  end

  retry_chg_mon_fifo #(
    .Width($bits(evt_t)),
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (gnt_vld),
    .i_pop  (fifo_pop),
    .i_wdata(push_evt),
    .o_rdata(head_evt),
    .o_level(o_fifo_level),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );

  assign o_evt_valid = ~fifo_empty;
  assign o_evt_ch    = head_evt.ch;
  assign o_evt_old   = head_evt.old_val;
  assign o_evt_new   = head_evt.new_val;
  assign o_evt_ts    = head_evt.ts;
  assign o_evt_coal  = head_evt.coal;
  assign o_coal_cnt  = coal_cnt_q;

`ifdef RETRY_CHG_MON_DISPLAY_EN
  for (genvar k = 0; k < NUM_CH; k++) begin : g_chg_msg
    chg_report : assert property (@(posedge i_clk)
        disable iff (!i_rst_n || state_q != StArmed || !i_ch_mask[k])
        ch_val[k] == prev_q[k])
      else $display("%s ch %0d changed: %0h ----> %0h, @time = %0t", MsgPrefix, k,
                    $sampled(prev_q[k]), $sampled(ch_val[k]), $time);
  end

  evt_stable : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      o_evt_valid && !i_evt_ready |=>
      o_evt_valid && $stable({o_evt_ch, o_evt_old, o_evt_new, o_evt_ts, o_evt_coal}));

  no_overflow : assert property (@(posedge i_clk) disable iff (!i_rst_n)
      !(gnt_vld && fifo_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_retry_change_monitor.sv
// Directed bench: default-parameter monitor plus a small (depth 2, 4-bit counter) instance.
module tb_retry_change_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // Main instance, default parameters.
  logic         observer_on, clr, ready;
  logic [63:0]  ch_data;
  logic [7:0]   ch_mask;
  logic         evt_valid, evt_coal;
  logic [2:0]   evt_ch;
  logic [7:0]   evt_old, evt_new;
  logic [31:0]  evt_ts;
  logic [4:0]   level;
  logic [127:0] chg_cnt;
  logic [15:0]  coal_cnt;

  // Small instance: 4 channels, FIFO depth 2, 16-bit timestamp, 4-bit counters.
  logic         b_observer_on, b_clr, b_ready;
  logic [31:0]  b_data;
  logic [3:0]   b_mask;
  logic         b_valid, b_coal;
  logic [1:0]   b_ch;
  logic [7:0]   b_old, b_new;
  logic [15:0]  b_ts;
  logic [1:0]   b_level;
  logic [15:0]  b_chg_cnt;
  logic [3:0]   b_coal_cnt;

  retry_change_monitor dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_observer_on(observer_on),
    .i_ch_data    (ch_data),
    .i_ch_mask    (ch_mask),
    .i_clr_cnt    (clr),
    .o_evt_valid  (evt_valid),
    .i_evt_ready  (ready),
    .o_evt_ch     (evt_ch),
    .o_evt_old    (evt_old),
    .o_evt_new    (evt_new),
    .o_evt_ts     (evt_ts),
    .o_evt_coal   (evt_coal),
    .o_fifo_level (level),
    .o_chg_cnt    (chg_cnt),
    .o_coal_cnt   (coal_cnt)
  );

  retry_change_monitor #(
    .NUM_CH    (4),
    .CH_W      (8),
    .FIFO_DEPTH(2),
    .TS_W      (16),
    .CNT_W     (4)
  ) dut_b (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_observer_on(b_observer_on),
    .i_ch_data    (b_data),
    .i_ch_mask    (b_mask),
    .i_clr_cnt    (b_clr),
    .o_evt_valid  (b_valid),
    .i_evt_ready  (b_ready),
    .o_evt_ch     (b_ch),
    .o_evt_old    (b_old),
    .o_evt_new    (b_new),
    .o_evt_ts     (b_ts),
    .o_evt_coal   (b_coal),
    .o_fifo_level (b_level),
    .o_chg_cnt    (b_chg_cnt),
    .o_coal_cnt   (b_coal_cnt)
  );

  // Cycles since reset release: the expected timestamp of a change made before the next edge.
  int unsigned cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic set_ch(input int k, input logic [7:0] v);
    ch_data[k*8 +: 8] = v;
  endtask

  task automatic b_set(input int k, input logic [7:0] v);
    b_data[k*8 +: 8] = v;
  endtask

  task automatic check_head(input string tag, input int ch, input logic [7:0] o,
                            input logic [7:0] n, input int unsigned ts, input logic c);
    check({tag, "_valid"}, evt_valid, 1'b1);
    check({tag, "_ch"}, evt_ch, ch[2:0]);
    check({tag, "_old"}, evt_old, o);
    check({tag, "_new"}, evt_new, n);
    check({tag, "_ts"}, evt_ts, ts);
    check({tag, "_coal"}, evt_coal, c);
  endtask

  task automatic check_b_head(input string tag, input int ch, input logic [7:0] o,
                              input logic [7:0] n, input int unsigned ts, input logic c);
    check({tag, "_valid"}, b_valid, 1'b1);
    check({tag, "_ch"}, b_ch, ch[1:0]);
    check({tag, "_old"}, b_old, o);
    check({tag, "_new"}, b_new, n);
    check({tag, "_ts"}, b_ts, ts[15:0]);
    check({tag, "_coal"}, b_coal, c);
  endtask

  int unsigned t_n;
  int unsigned b_t [4];
  int exp_cnt [8] = '{2, 1, 1, 1, 0, 1, 1, 1};

  initial begin
    observer_on = 0; clr = 0; ready = 0; ch_mask = 8'hFF;
    ch_data = 64'h8070_6050_4000_2010;
    b_observer_on = 0; b_clr = 0; b_ready = 0; b_mask = 4'hF; b_data = '0;

    #1 rst_n = 0;
    @(negedge clk);
    check("rst_valid", evt_valid, 0);
    check("rst_level", level, 0);
    check("rst_chg_cnt", chg_cnt, 0);
    check("rst_coal_cnt", coal_cnt, 0);
    check("rst_evt_ts", evt_ts, 0);

    // Prime with non-zero data: nothing is reported.
    rst_n = 1;
    observer_on = 1;
    tick(4);
    check("prime_valid", evt_valid, 0);
    check("prime_level", level, 0);
    check("prime_chg_cnt", chg_cnt, 0);

    // Simultaneous changes on ch0, ch3, ch7.
    set_ch(0, 8'h11); set_ch(3, 8'h44); set_ch(7, 8'h88);
    t_n = cyc;
    tick(1);
    check("sim_latency", evt_valid, 0);
    tick(3);
    check("sim_peak_level", level, 3);
    ready = 1;
    check_head("sim0", 0, 8'h10, 8'h11, t_n, 0); tick(1);
    check_head("sim3", 3, 8'h40, 8'h44, t_n, 0); tick(1);
    check_head("sim7", 7, 8'h80, 8'h88, t_n, 0); tick(1);
    check("sim_empty", evt_valid, 0);
    ready = 0;

    // Single change ch2 0x00 -> 0x5A.
    set_ch(2, 8'h5A);
    t_n = cyc;
    tick(1);
    check("single_lat1", evt_valid, 0);
    tick(1);
    check_head("single", 2, 8'h00, 8'h5A, t_n, 0);
    check("single_cnt2", chg_cnt[2*16 +: 16], 1);
    ready = 1; tick(1); ready = 0;
    check("single_empty", evt_valid, 0);

    // Masked channel toggles, then unmask: no stale difference.
    ch_mask = 8'hEF;
    set_ch(4, 8'h55); tick(1);
    set_ch(4, 8'h56); tick(1);
    ch_mask = 8'hFF;
    tick(3);
    check("mask_valid", evt_valid, 0);
    check("mask_cnt4", chg_cnt[4*16 +: 16], 0);

    // Drop observer with two slots still pending.
    set_ch(1, 8'h21); set_ch(5, 8'h65); set_ch(6, 8'h76);
    t_n = cyc;
    tick(2);
    observer_on = 0;
    tick(3);
    check("drop_level", level, 1);
    check_head("drop5", 5, 8'h60, 8'h65, t_n, 0);
    set_ch(0, 8'h99);
    ready = 1; tick(1); ready = 0;
    check("drop_drained", level, 0);
    observer_on = 1;
    tick(4);
    check("reprime_valid", evt_valid, 0);
    set_ch(0, 8'h9A);
    t_n = cyc;
    tick(2);
    check_head("rearm", 0, 8'h99, 8'h9A, t_n, 0);
    for (int k = 0; k < 8; k++) check($sformatf("cnt_ch%0d", k), chg_cnt[k*16 +: 16], exp_cnt[k]);
    check("main_coal_cnt", coal_cnt, 0);
    ready = 1; tick(1); ready = 0;

    // Clear wins over a same-edge increment and leaves the event path alone.
    set_ch(3, 8'h45);
    t_n = cyc;
    clr = 1; tick(1); clr = 0;
    check("clr_chg_cnt", chg_cnt, 0);
    tick(1);
    check_head("clr_fifo", 3, 8'h44, 8'h45, t_n, 0);
    ready = 1; tick(1); ready = 0;

    // Fill to five entries, then reset mid-run.
    set_ch(0, 8'h9B); set_ch(1, 8'h22); set_ch(2, 8'h5B); set_ch(3, 8'h46); set_ch(4, 8'h57);
    tick(7);
    check("mid_level5", level, 5);
    rst_n = 0;
    #1;
    check("mid_rst_valid", evt_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_chg_cnt", chg_cnt, 0);
    check("mid_rst_new", evt_new, 0);
    check("mid_rst_ts", evt_ts, 0);
    @(negedge clk);
    rst_n = 1;

    // Small instance: backpressure and coalescing on ch1.
    b_observer_on = 1;
    tick(3);
    for (int i = 0; i < 4; i++) begin
      b_set(1, 8'(i + 1));
      b_t[i] = cyc;
      tick(1);
    end
    tick(2);
    check("bp_level", b_level, 2);
    check("bp_coal_cnt", b_coal_cnt, 1);
    check("bp_cnt1", b_chg_cnt[4 +: 4], 4);
    b_ready = 1;
    check_b_head("bp0", 1, 8'h00, 8'h01, b_t[0], 0); tick(1);
    check_b_head("bp1", 1, 8'h01, 8'h02, b_t[1], 0);
    check("bp_refill_level", b_level, 2);
    tick(1);
    check_b_head("bp2", 1, 8'h02, 8'h04, b_t[2], 1); tick(1);
    check("bp_empty", b_valid, 0);

    // Saturation of a 4-bit change counter, then clear.
    for (int i = 0; i < 20; i++) begin
      b_set(2, 8'(i + 1));
      tick(1);
    end
    tick(3);
    check("sat_cnt2", b_chg_cnt[8 +: 4], 15);
    check("sat_coal_cnt", b_coal_cnt, 1);
    b_clr = 1; tick(1); b_clr = 0;
    check("sat_clr_cnt", b_chg_cnt, 0);
    check("sat_clr_coal", b_coal_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
